// File: rtl/yutorina_bus_master_if.sv
// Initiator-side Yutorina bus interface: turns a single-cycle CPU access into a
// request/grant/strobe/ready bus transaction and stalls the CPU while it runs.
module yutorina_bus_master_if (
  input  logic        clock,
  input  logic        reset,
  input  logic        cpu_request,
  input  logic        cpu_read_write,
  input  logic [29:0] cpu_address,
  input  logic [31:0] cpu_write_data,
  input  logic        stall,
  input  logic        flush,
  output logic [31:0] cpu_read_data,
  output logic        busy,
  output logic        bus_request_,
  input  logic        bus_grant_,
  output logic [29:0] bus_address,
  output logic        bus_address_strobe_,
  output logic        bus_read_write,
  output logic [31:0] bus_write_data,
  input  logic [31:0] bus_read_data,
  input  logic        bus_ready_
);

  localparam int DATA_W = 32;
  localparam int ADDR_W = 30;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQUEST = 2'd1,
    ST_ACCESS  = 2'd2,
    ST_WAIT    = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic                req_n_q, req_n_d;
  logic                as_n_q, as_n_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                rw_q, rw_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  always_comb begin
    state_d = state_q;
    req_n_d = req_n_q;
    as_n_d  = 1'b1;
    addr_d  = addr_q;
    rw_d    = rw_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (cpu_request && !flush) begin
          addr_d  = cpu_address;
          rw_d    = cpu_read_write;
          wdata_d = cpu_write_data;
          req_n_d = 1'b0;
          state_d = ST_REQUEST;
        end
      end
      ST_REQUEST: begin
        // A flush beats a same-cycle grant; releasing the request frees the arbiter.
        if (flush) begin
          req_n_d = 1'b1;
          state_d = ST_IDLE;
        end else if (!bus_grant_) begin
          as_n_d  = 1'b0;
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (!bus_ready_) begin
          req_n_d = 1'b1;
          if (rw_q) rdata_d = bus_read_data;
          state_d = stall ? ST_WAIT : ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (!stall) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      req_n_q <= 1'b1;
      as_n_q  <= 1'b1;
      addr_q  <= '0;
      rw_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      req_n_q <= req_n_d;
      as_n_q  <= as_n_d;
      addr_q  <= addr_d;
      rw_q    <= rw_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  logic drive_bus;
  assign drive_bus = (state_q != ST_IDLE);

  assign busy = ((state_q == ST_IDLE) && cpu_request && !flush) ||
                (state_q == ST_REQUEST) || (state_q == ST_ACCESS);

  assign cpu_read_data       = rdata_q;
  assign bus_request_        = req_n_q;
  assign bus_address_strobe_ = as_n_q;
  assign bus_address         = drive_bus ? addr_q  : '0;
  assign bus_read_write      = drive_bus ? rw_q    : 1'b0;
  assign bus_write_data      = drive_bus ? wdata_q : '0;

endmodule

// File: tb/tb_yutorina_bus_master_if.sv
// Bench for yutorina_bus_master_if: fixed transaction table, hand-written corner
// sequences, and randomized transactions against a cycle-count reference model.
module tb_yutorina_bus_master_if;

  logic        clock;
  logic        reset;
  logic        cpu_request;
  logic        cpu_read_write;
  logic [29:0] cpu_address;
  logic [31:0] cpu_write_data;
  logic        stall;
  logic        flush;
  logic [31:0] cpu_read_data;
  logic        busy;
  logic        bus_request_;
  logic        bus_grant_;
  logic [29:0] bus_address;
  logic        bus_address_strobe_;
  logic        bus_read_write;
  logic [31:0] bus_write_data;
  logic [31:0] bus_read_data;
  logic        bus_ready_;

  yutorina_bus_master_if dut (
    .clock               (clock),
    .reset               (reset),
    .cpu_request         (cpu_request),
    .cpu_read_write      (cpu_read_write),
    .cpu_address         (cpu_address),
    .cpu_write_data      (cpu_write_data),
    .stall               (stall),
    .flush               (flush),
    .cpu_read_data       (cpu_read_data),
    .busy                (busy),
    .bus_request_        (bus_request_),
    .bus_grant_          (bus_grant_),
    .bus_address         (bus_address),
    .bus_address_strobe_ (bus_address_strobe_),
    .bus_read_write      (bus_read_write),
    .bus_write_data      (bus_write_data),
    .bus_read_data       (bus_read_data),
    .bus_ready_          (bus_ready_)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] model_rd;

  typedef struct {
    logic        rw;
    logic [29:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          g;
    int          r;
    int          s;
    int          exp_busy;
    logic [31:0] exp_rd;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_req"},   {31'd0, bus_request_}, 32'd1);
    chk({tag, "_as"},    {31'd0, bus_address_strobe_}, 32'd1);
    chk({tag, "_addr"},  {2'd0, bus_address}, 32'd0);
    chk({tag, "_rw"},    {31'd0, bus_read_write}, 32'd0);
    chk({tag, "_wdata"}, bus_write_data, 32'd0);
    chk({tag, "_rdata"}, cpu_read_data, model_rd);
  endtask

  // IDLE cycles with grant/ready/stall noise that must be ignored.
  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      cpu_request   = 1'b0;
      flush         = 1'($urandom);
      stall         = 1'($urandom);
      bus_grant_    = 1'($urandom);
      bus_ready_    = 1'($urandom);
      bus_read_data = $urandom;
      #1;
      chk("idle_busy", {31'd0, busy}, 32'd0);
      chk_idle_outputs("idle");
    end
  endtask

  // One transaction: grant arrives g cycles late, ready r cycles late, stall
  // held so that s WAIT cycles follow the ready cycle.
  task automatic run_txn(input logic rw, input logic [29:0] addr, input logic [31:0] wd,
                         input logic [31:0] rd, input int g, input int r, input int s,
                         input int exp_busy, input logic [31:0] exp_rd);
    int last;
    int nbusy;
    last  = 2 + g + r;
    nbusy = 0;
    for (int k = 0; k <= last; k++) begin
      @(negedge clock);
      cpu_request    = (k == 0);
      cpu_read_write = (k == 0) ? rw   : 1'($urandom);
      cpu_address    = (k == 0) ? addr : 30'($urandom);
      cpu_write_data = (k == 0) ? wd   : $urandom;
      flush          = 1'b0;
      bus_grant_     = !(k >= 1 + g);
      bus_ready_     = !(k == last);
      bus_read_data  = (k == last) ? rd : $urandom;
      stall          = (k == last) ? (s > 0) : 1'($urandom);
      #1;
      if (busy) nbusy++;
      if (k == 0) begin
        chk("accept_busy", {31'd0, busy}, 32'd1);
        chk_idle_outputs("accept");
      end else begin
        chk("txn_busy",  {31'd0, busy}, 32'd1);
        chk("txn_req",   {31'd0, bus_request_}, 32'd0);
        chk("txn_as",    {31'd0, bus_address_strobe_}, {31'd0, (k != 2 + g)});
        chk("txn_addr",  {2'd0, bus_address}, {2'd0, addr});
        chk("txn_rw",    {31'd0, bus_read_write}, {31'd0, rw});
        chk("txn_wdata", bus_write_data, wd);
      end
    end
    if (rw) model_rd = rd;
    for (int w = 0; w < s; w++) begin
      @(negedge clock);
      cpu_request    = 1'($urandom);
      cpu_read_write = 1'($urandom);
      cpu_address    = 30'($urandom);
      cpu_write_data = $urandom;
      flush          = 1'b0;
      stall          = (w < s - 1);
      bus_grant_     = 1'($urandom);
      bus_ready_     = 1'($urandom);
      bus_read_data  = $urandom;
      #1;
      chk("wait_busy",  {31'd0, busy}, 32'd0);
      chk("wait_req",   {31'd0, bus_request_}, 32'd1);
      chk("wait_as",    {31'd0, bus_address_strobe_}, 32'd1);
      chk("wait_addr",  {2'd0, bus_address}, {2'd0, addr});
      chk("wait_rdata", cpu_read_data, model_rd);
    end
    chk("busy_cycles", nbusy, exp_busy);
    @(posedge clock);
    #1;
    chk("done_rdata", cpu_read_data, exp_rd);
    chk("done_req",   {31'd0, bus_request_}, 32'd1);
  endtask

  vec_t vecs[5];

  initial begin
    reset = 1'b1; cpu_request = 1'b0; cpu_read_write = 1'b0; cpu_address = '0;
    cpu_write_data = '0; stall = 1'b0; flush = 1'b0; bus_grant_ = 1'b1;
    bus_read_data = '0; bus_ready_ = 1'b1;
    model_rd = '0;

    vecs[0] = '{1'b1, 30'h0000_0010, 32'h0,         32'hDEAD_BEEF, 0, 0, 0, 3, 32'hDEAD_BEEF};
    vecs[1] = '{1'b0, 30'h3FFF_FFFF, 32'h1234_5678, 32'hFFFF_0000, 2, 3, 0, 8, 32'hDEAD_BEEF};
    vecs[2] = '{1'b1, 30'h0000_0155, 32'h0,         32'hA5A5_5A5A, 1, 0, 3, 4, 32'hA5A5_5A5A};
    vecs[3] = '{1'b1, 30'h0000_0100, 32'h0,         32'h1111_1111, 0, 0, 0, 3, 32'h1111_1111};
    vecs[4] = '{1'b1, 30'h0000_0101, 32'h0,         32'h2222_2222, 0, 0, 0, 3, 32'h2222_2222};

    #2 reset = 1'b0;
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk_idle_outputs("rst");
    @(negedge clock);
    reset = 1'b1;

    idle_cycles(2);
    for (int i = 0; i < 5; i++)
      run_txn(vecs[i].rw, vecs[i].addr, vecs[i].wdata, vecs[i].rdata,
              vecs[i].g, vecs[i].r, vecs[i].s, vecs[i].exp_busy, vecs[i].exp_rd);
    idle_cycles(1);

    // Flush: refused in IDLE, then cancels a REQUEST despite a same-cycle grant.
    @(negedge clock);
    cpu_request = 1'b1; flush = 1'b1; cpu_address = 30'h77; bus_grant_ = 1'b1; bus_ready_ = 1'b1;
    #1 chk("flush_idle_busy", {31'd0, busy}, 32'd0);
    @(negedge clock);
    flush = 1'b0; cpu_read_write = 1'b1;
    #1 chk("flush_acc_busy", {31'd0, busy}, 32'd1);
    @(negedge clock);
    cpu_request = 1'b0; flush = 1'b1; bus_grant_ = 1'b0;
    #1;
    chk("flush_req_busy", {31'd0, busy}, 32'd1);
    chk("flush_req_req",  {31'd0, bus_request_}, 32'd0);
    chk("flush_req_addr", {2'd0, bus_address}, 32'h77);
    @(negedge clock);
    flush = 1'b0; bus_grant_ = 1'b0;
    #1;
    chk("flush_after_busy", {31'd0, busy}, 32'd0);
    chk_idle_outputs("flush_after");
    @(negedge clock);
    #1 chk("flush_after2_as", {31'd0, bus_address_strobe_}, 32'd1);

    // Reset mid-ACCESS while the strobe is low.
    @(negedge clock);
    cpu_request = 1'b1; cpu_read_write = 1'b1; cpu_address = 30'h2A; bus_grant_ = 1'b1; bus_ready_ = 1'b1;
    @(negedge clock);
    cpu_request = 1'b0; bus_grant_ = 1'b0;
    @(negedge clock);
    #1 chk("rstmid_as_before", {31'd0, bus_address_strobe_}, 32'd0);
    reset = 1'b0;
    model_rd = '0;
    #1;
    chk("rstmid_busy", {31'd0, busy}, 32'd0);
    chk_idle_outputs("rstmid");
    @(negedge clock);
    reset = 1'b1; bus_grant_ = 1'b1;
    run_txn(1'b1, 30'h0000_0abc, 32'h0, 32'hCAFE_F00D, 0, 1, 0, 4, 32'hCAFE_F00D);

    // Randomized transactions against the cycle-count model.
    for (int t = 0; t < 40; t++) begin
      logic        rw;
      logic [29:0] a;
      logic [31:0] wd, rd;
      int          g, r, s;
      rw = 1'($urandom); a = 30'($urandom); wd = $urandom; rd = $urandom;
      g = $urandom_range(0, 3); r = $urandom_range(0, 3); s = $urandom_range(0, 2);
      run_txn(rw, a, wd, rd, g, r, s, 3 + g + r, rw ? rd : model_rd);
      idle_cycles($urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/yutorina_bus_master_if.md
# yutorina_bus_master_if

Initiator-side bus interface connecting one CPU-internal access port (instruction fetch or memory stage) to one master port of the shared Yutorina bus. It converts a single-cycle CPU access request into the full bus transaction: request, wait for grant, single-cycle address strobe, wait for slave ready, then release. It returns read data to the CPU and stalls the CPU via `busy` while the transaction is in flight.

## Interface
- none: no parameters. Data word is fixed at 32 bits (`YutorinaWordDataBus`); the word address is fixed at 30 bits (`YutorinaWordAddressBus`).

Ports:
- `clock`  in  1  system clock; all state updates on its rising edge
- `reset`  in  1  asynchronous, active-low reset
- `cpu_request`  in  1  high = access requested this cycle
- `cpu_read_write`  in  1  1 = read, 0 = write
- `cpu_address`  in  30  word address
- `cpu_write_data`  in  32  write data
- `stall`  in  1  pipeline stall; holds a completed result
- `flush`  in  1  pipeline flush; cancels a not-yet-started access
- `cpu_read_data`  out  32  registered read data
- `busy`  out  1  high = CPU must stall
- `bus_request_`  out  1  active-low bus request to the arbiter
- `bus_grant_`  in  1  active-low grant from the arbiter
- `bus_address`  out  30  address to the master multiplexer
- `bus_address_strobe_`  out  1  active-low address strobe
- `bus_read_write`  out  1  1 = read, 0 = write
- `bus_write_data`  out  32  write data
- `bus_read_data`  in  32  read data from the slave multiplexer
- `bus_ready_`  in  1  active-low slave ready

## Operation
The block is a four-state machine: IDLE, REQUEST, ACCESS, WAIT.

- **IDLE**
  - If `cpu_request=1` and `flush=0`: latch `cpu_address`, `cpu_read_write` and `cpu_write_data`; drive `bus_request_` low (registered); go to REQUEST.
  - Otherwise stay in IDLE.
- **REQUEST**
  - If `flush=1`: drive `bus_request_` high and go to IDLE. No strobe is ever issued.
  - Else if `bus_grant_=0`: drive `bus_address_strobe_` low (registered); go to ACCESS.
  - Else stay, keeping `bus_request_` low.
- **ACCESS**
  - `bus_address_strobe_` is low only in the first ACCESS cycle. It returns high at the next edge whatever `bus_ready_` does.
  - When `bus_ready_=0`:
    - drive `bus_request_` high;
    - if the access is a read, register `bus_read_data` into `cpu_read_data`;
    - go to WAIT if `stall=1`, else to IDLE.
  - `flush` is ignored in ACCESS; a started transaction always completes.
- **WAIT**
  - Hold `cpu_read_data`.
  - Go to IDLE when `stall=0`.
  - No new request is accepted in WAIT.
- **`busy`** (combinational) = (IDLE and `cpu_request` and not `flush`) or REQUEST or ACCESS. It is 0 in WAIT.
- **Bus output drive**
  - `bus_address`, `bus_read_write` and `bus_write_data` carry the latched values in REQUEST, ACCESS and WAIT.
  - In IDLE they are driven to 0, 0 (write) and 0.
- **Write accesses** leave `cpu_read_data` unchanged.
- **Reset** (`reset=0`, asynchronous, valid at any point including mid-transaction):
  - state = IDLE;
  - `bus_request_` = 1 and `bus_address_strobe_` = 1;
  - latched address, read/write and write data = 0;
  - `cpu_read_data` = 0;
  - `busy` = 0 unless `cpu_request` is high.

## Timing
- Request accepted in cycle 0 (IDLE, `busy=1`).
- Cycle 1: REQUEST, `bus_request_=0`.
- Each cycle `bus_grant_` stays high adds one REQUEST cycle.
- First ACCESS cycle follows the grant cycle; `bus_address_strobe_` is low for exactly that one cycle.
- Each cycle `bus_ready_` stays high adds one ACCESS cycle.
- Cycle after ready: `busy=0`, `cpu_read_data` valid, `bus_request_=1`.
- Minimum latency, with grant already low in cycle 1 and ready low in cycle 2: result in cycle 3.
- A new request may be accepted in the first IDLE cycle after completion, giving back-to-back accesses every 3 cycles minimum.
- `bus_ready_`/`bus_grant_` low while in IDLE or WAIT: ignored.
- `flush` and `bus_grant_=0` in the same REQUEST cycle: flush wins, and the grant is released by `bus_request_` going high next cycle.

## Test plan
- **Read, zero wait:** read of address 30'h0000_0010 with grant low in cycle 1 and ready low in cycle 2, `bus_read_data`=32'hDEAD_BEEF → strobe low in cycle 2 only; cycle 3 `busy=0`, `cpu_read_data`=32'hDEAD_BEEF, `bus_request_=1`.
- **Write with waits:** write of 32'h1234_5678 to 30'h3FFF_FFFF; grant delayed 2 cycles, ready delayed 3 → strobe low exactly 1 cycle, `busy=1` for 8 cycles, `cpu_read_data` unchanged, `bus_write_data` stable throughout.
- **Flush in REQUEST:** flush during REQUEST with grant low the same cycle → no strobe, next cycle IDLE, `bus_request_=1`, `busy=0`.
- **Stall at completion:** `stall=1` when ready arrives → WAIT, data held while `stall` stays high for 3 cycles, a `cpu_request` during WAIT is not accepted; `stall` drops → IDLE.
- **Reset mid-transaction:** `reset` low mid-ACCESS → outputs reach reset values immediately (before the next edge); after release, a new read completes normally.
- **Back-to-back reads:** two consecutive reads → second transaction starts in the cycle after the first completes; both data values returned correctly.
